// File: rtl/udp_tx_arb_pkg.sv
// Shared types and the round-robin pick helper for the UDP TX source arbiter.
package udp_tx_arb_pkg;

    localparam int IP_ADDR_W       = 32;
    localparam int MAC_INTERFACE_W = 64;
    localparam int MAC_PADBYTES_W  = 3;
    localparam int MAX_SRC         = 16;
    localparam int MAX_SRC_W       = 4;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] chksum;
    } udp_pkt_hdr;

    localparam int UDP_HDR_W = $bits(udp_pkt_hdr);

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HDR  = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic                 found;
        logic [MAX_SRC_W-1:0] idx;
    } rr_pick_t;

    // First requester at or after ptr, searching upward and wrapping at num_src.
    function automatic rr_pick_t rr_pick(input logic [MAX_SRC-1:0] req,
                                         input logic [MAX_SRC_W-1:0] ptr,
                                         input int num_src);
        rr_pick_t r;
        int       idx;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < MAX_SRC; i++) begin
            idx = (int'(ptr) + i) % num_src;
            if (!r.found && (i < num_src) && req[idx[MAX_SRC_W-1:0]]) begin
                r.found = 1'b1;
                r.idx   = idx[MAX_SRC_W-1:0];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin selection of one requester starting at ptr.
module rr_arbiter_pick
    import udp_tx_arb_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   grant,
    output logic               grant_val
);

    logic [MAX_SRC-1:0] req_w;
    rr_pick_t           pick_s;

    // Widen the request vector to the helper's fixed width and pick.
    always_comb begin
        req_w                = '0;
        req_w[NUM_SRC-1:0]   = req;
        pick_s               = rr_pick(req_w, MAX_SRC_W'(ptr), NUM_SRC);
        grant                = SRC_W'(pick_s.idx);
        grant_val            = pick_s.found;
    end

endmodule

// File: rtl/udp_tx_src_arbiter.sv
// Packet-granular round-robin sharing of one UDP TX header+data port among NUM_SRC senders.
module udp_tx_src_arbiter
    import udp_tx_arb_pkg::*;
#(
    parameter  int NUM_SRC = 2,
    parameter  int CNT_W   = 32,
    localparam int SRC_W   = $clog2(NUM_SRC)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_SRC-1:0]                    src_tx_hdr_val,
    input  logic [NUM_SRC*IP_ADDR_W-1:0]          src_tx_src_ip,
    input  logic [NUM_SRC*IP_ADDR_W-1:0]          src_tx_dst_ip,
    input  logic [NUM_SRC*UDP_HDR_W-1:0]          src_tx_udp_hdr,
    output logic [NUM_SRC-1:0]                    arb_src_tx_hdr_rdy,
    input  logic [NUM_SRC-1:0]                    src_tx_data_val,
    input  logic [NUM_SRC*MAC_INTERFACE_W-1:0]    src_tx_data,
    input  logic [NUM_SRC-1:0]                    src_tx_last,
    input  logic [NUM_SRC*MAC_PADBYTES_W-1:0]     src_tx_padbytes,
    output logic [NUM_SRC-1:0]                    arb_src_tx_data_rdy,
    output logic                                  arb_udp_tx_hdr_val,
    output logic [IP_ADDR_W-1:0]                  arb_udp_tx_src_ip,
    output logic [IP_ADDR_W-1:0]                  arb_udp_tx_dst_ip,
    output udp_pkt_hdr                            arb_udp_tx_udp_hdr,
    input  logic                                  udp_arb_tx_hdr_rdy,
    output logic                                  arb_udp_tx_data_val,
    output logic [MAC_INTERFACE_W-1:0]            arb_udp_tx_data,
    output logic                                  arb_udp_tx_last,
    output logic [MAC_PADBYTES_W-1:0]             arb_udp_tx_padbytes,
    input  logic                                  udp_arb_tx_data_rdy,
    output logic [NUM_SRC*CNT_W-1:0]              pkt_cnt
);

    arb_state_e           state_r;
    logic [SRC_W-1:0]     grant_r;
    logic [SRC_W-1:0]     rr_ptr_r;
    logic [CNT_W-1:0]     cnt_r [NUM_SRC];

    logic [SRC_W-1:0]     pick_grant_s;
    logic                 pick_val_s;
    logic                 hdr_hs_s;
    logic                 done_s;

    logic [IP_ADDR_W-1:0]       sip_a  [NUM_SRC];
    logic [IP_ADDR_W-1:0]       dip_a  [NUM_SRC];
    udp_pkt_hdr                 uh_a   [NUM_SRC];
    logic [MAC_INTERFACE_W-1:0] dat_a  [NUM_SRC];
    logic [MAC_PADBYTES_W-1:0]  pad_a  [NUM_SRC];

    rr_arbiter_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req       (src_tx_hdr_val),
        .ptr       (rr_ptr_r),
        .grant     (pick_grant_s),
        .grant_val (pick_val_s)
    );

    // Unpack the flat per-source buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            sip_a[i] = src_tx_src_ip[i*IP_ADDR_W +: IP_ADDR_W];
            dip_a[i] = src_tx_dst_ip[i*IP_ADDR_W +: IP_ADDR_W];
            uh_a[i]  = src_tx_udp_hdr[i*UDP_HDR_W +: UDP_HDR_W];
            dat_a[i] = src_tx_data[i*MAC_INTERFACE_W +: MAC_INTERFACE_W];
            pad_a[i] = src_tx_padbytes[i*MAC_PADBYTES_W +: MAC_PADBYTES_W];
        end
    end

    assign hdr_hs_s = (state_r == ARB_HDR) && src_tx_hdr_val[grant_r] && udp_arb_tx_hdr_rdy;
    assign done_s   = (state_r == ARB_DATA) && src_tx_data_val[grant_r] &&
                      udp_arb_tx_data_rdy && src_tx_last[grant_r];

    // Arbitration FSM; the pointer advances past the winner only when its packet completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ARB_IDLE;
            grant_r  <= '0;
            rr_ptr_r <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if (pick_val_s) begin
                        grant_r <= pick_grant_s;
                        state_r <= ARB_HDR;
                    end
                end
                ARB_HDR: begin
                    if (hdr_hs_s) begin
                        state_r <= ARB_DATA;
                    end
                end
                ARB_DATA: begin
                    if (done_s) begin
                        state_r        <= ARB_IDLE;
                        rr_ptr_r       <= (grant_r == SRC_W'(NUM_SRC - 1)) ? '0 : grant_r + 1'b1;
                        cnt_r[grant_r] <= cnt_r[grant_r] + CNT_W'(1);
                    end
                end
                default: state_r <= ARB_IDLE;
            endcase
        end
    end

    // Forward the granted source; payload is forced to zero whenever its valid is low.
    always_comb begin
        arb_src_tx_hdr_rdy  = '0;
        arb_src_tx_data_rdy = '0;
        arb_udp_tx_hdr_val  = (state_r == ARB_HDR) && src_tx_hdr_val[grant_r];
        arb_udp_tx_data_val = (state_r == ARB_DATA) && src_tx_data_val[grant_r];
        if (arb_udp_tx_hdr_val) begin
            arb_udp_tx_src_ip  = sip_a[grant_r];
            arb_udp_tx_dst_ip  = dip_a[grant_r];
            arb_udp_tx_udp_hdr = uh_a[grant_r];
        end else begin
            arb_udp_tx_src_ip  = '0;
            arb_udp_tx_dst_ip  = '0;
            arb_udp_tx_udp_hdr = '0;
        end
        if (arb_udp_tx_data_val) begin
            arb_udp_tx_data     = dat_a[grant_r];
            arb_udp_tx_last     = src_tx_last[grant_r];
            arb_udp_tx_padbytes = pad_a[grant_r];
        end else begin
            arb_udp_tx_data     = '0;
            arb_udp_tx_last     = 1'b0;
            arb_udp_tx_padbytes = '0;
        end
        if (state_r == ARB_HDR) begin
            arb_src_tx_hdr_rdy[grant_r] = udp_arb_tx_hdr_rdy;
        end else begin
            arb_src_tx_hdr_rdy = '0;
        end
        if (state_r == ARB_DATA) begin
            arb_src_tx_data_rdy[grant_r] = udp_arb_tx_data_rdy;
        end else begin
            arb_src_tx_data_rdy = '0;
        end
    end

    // Flatten the per-source packet counters.
    always_comb begin
        pkt_cnt = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pkt_cnt[i*CNT_W +: CNT_W] = cnt_r[i];
        end
    end

endmodule
